fp64_operand_loader: RTL and testbench

//  Upstream feeder for the double-precision comparator. Assembles two IEEE-754 binary64

---
 rtl/fp64_operand_loader.sv | 119 +++++++++++
 tb/tb_fp64_operand_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp64_operand_loader.sv
// Assembles two binary64 operands (A then B) from a narrow word stream and
// presents them with IEEE-754 class codes under a valid/ready handshake.
module fp64_operand_loader #(
  parameter int WORD_W    = 16,
  parameter bit MSW_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_first,
  output logic              in_ready,
  output logic [63:0]       A_64,
  output logic [63:0]       B_64,
  output logic [2:0]        a_class,
  output logic [2:0]        b_class,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err
);

  localparam int N = 64 / WORD_W;
  localparam logic [2:0] LAST = 3'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        accept;
  logic        last_word;
  logic [63:0] b_next;

  // Word k of an operand lands in slot k, or slot N-1-k when the stream is MSW first.
  function automatic logic [63:0] place(input logic [63:0] base,
                                        input logic [WORD_W-1:0] word,
                                        input logic [2:0] k);
    logic [63:0] r;
    r = base;
    for (int i = 0; i < N; i++) begin
      if (k == 3'(MSW_FIRST ? (N - 1 - i) : i)) r[i*WORD_W +: WORD_W] = word;
    end
    return r;
  endfunction

  function automatic logic [2:0] classify(input logic [62:0] v);
    logic [10:0] e;
    logic [51:0] f;
    e = v[62:52];
    f = v[51:0];
    if (e == 11'd0)           return (f == 52'd0) ? 3'd1 : 3'd2;
    else if (e == 11'h7FF) begin
      if (f == 52'd0)         return 3'd3;
      else if (f[51])         return 3'd4;
      else                    return 3'd5;
    end
    else                      return 3'd0;
  endfunction

  assign in_ready  = rst_n && (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign last_word = (cnt == LAST);
  assign b_next    = place(B_64, in_data, cnt);

  // in_first always wins: it restarts the frame from any loading state, even on the final B word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      A_64      <= 64'd0;
      B_64      <= 64'd0;
      a_class   <= 3'd0;
      b_class   <= 3'd0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state == HOLD) begin
        if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        if (in_first) begin
          frame_err <= (state != IDLE);
          A_64      <= place(A_64, in_data, 3'd0);
          if (N == 1) begin
            cnt   <= 3'd0;
            state <= LOAD_B;
          end else begin
            cnt   <= 3'd1;
            state <= LOAD_A;
          end
        end else if (state == IDLE) begin
          frame_err <= 1'b1;
        end else if (state == LOAD_A) begin
          A_64 <= place(A_64, in_data, cnt);
          if (last_word) begin
            cnt   <= 3'd0;
            state <= LOAD_B;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end else begin
          B_64 <= b_next;
          if (last_word) begin
            cnt       <= 3'd0;
            a_class   <= classify(A_64[62:0]);
            b_class   <= classify(b_next[62:0]);
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fp64_operand_loader.sv
// Randomized self-checking bench: operands are built per IEEE class and compared whole
// against the assembled outputs; three DUT configurations (16/LSW, 8/MSW, 64-bit words).
module tb_fp64_operand_loader;

  localparam int W = 16;
  localparam int N = 64 / W;
  localparam logic [63:0] P54 = 64'h401599999999999A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid, in_first, in_ready;
  logic [63:0] a_64, b_64;
  logic [2:0]  a_class, b_class;
  logic        out_valid, out_ready, frame_err;

  logic [7:0]  s8_data;
  logic        s8_valid, s8_first, s8_ready;
  logic [63:0] s8_a, s8_b;
  logic [2:0]  s8_ac, s8_bc;
  logic        s8_out_valid, s8_out_ready, s8_err;

  logic [63:0] s64_data;
  logic        s64_valid, s64_first, s64_ready;
  logic [63:0] s64_a, s64_b;
  logic [2:0]  s64_ac, s64_bc;
  logic        s64_out_valid, s64_out_ready, s64_err;

  fp64_operand_loader #(.WORD_W(16), .MSW_FIRST(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_first(in_first),
    .in_ready(in_ready), .A_64(a_64), .B_64(b_64), .a_class(a_class), .b_class(b_class),
    .out_valid(out_valid), .out_ready(out_ready), .frame_err(frame_err));

  fp64_operand_loader #(.WORD_W(8), .MSW_FIRST(1'b1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_data(s8_data), .in_valid(s8_valid), .in_first(s8_first),
    .in_ready(s8_ready), .A_64(s8_a), .B_64(s8_b), .a_class(s8_ac), .b_class(s8_bc),
    .out_valid(s8_out_valid), .out_ready(s8_out_ready), .frame_err(s8_err));

  fp64_operand_loader #(.WORD_W(64), .MSW_FIRST(1'b0)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_data(s64_data), .in_valid(s64_valid), .in_first(s64_first),
    .in_ready(s64_ready), .A_64(s64_a), .B_64(s64_b), .a_class(s64_ac), .b_class(s64_bc),
    .out_valid(s64_out_valid), .out_ready(s64_out_ready), .frame_err(s64_err));

  int n_checks = 0;
  int n_fails  = 0;
  bit gap_en   = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand64();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r;
  endfunction

  // Build an operand of the requested class (0..5) with random sign and payload.
  function automatic logic [63:0] make_operand(input int cat);
    logic [63:0] r;
    logic [10:0] e;
    logic [51:0] f;
    r = rand64();
    f = r[51:0];
    case (cat)
      0:       e = 11'(1 + $urandom_range(2045));
      1:       begin e = 11'd0; f = 52'd0; end
      2:       begin e = 11'd0; if (f == 52'd0) f = 52'd1; end
      3:       begin e = 11'h7FF; f = 52'd0; end
      4:       begin e = 11'h7FF; f[51] = 1'b1; end
      default: begin e = 11'h7FF; f[51] = 1'b0; if (f == 52'd0) f = 52'd1; end
    endcase
    return {r[63], e, f};
  endfunction

  function automatic logic [15:0] word_of(input logic [63:0] v, input int k);
    return 16'(v >> (k * W));
  endfunction

  task automatic applyStimulus(input logic [15:0] d, input logic f);
    int guard;
    if (gap_en && $urandom_range(3) == 0)
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    in_data  = d;
    in_valid = 1'b1;
    in_first = f;
    guard    = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    if (!in_ready) begin
      checkOutput("in_ready_wait", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      in_first = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_pair(input logic [63:0] a, input logic [63:0] b, input logic exp_err);
    for (int k = 0; k < N; k++) begin
      applyStimulus(word_of(a, k), k == 0);
      if (k == 0) checkOutput("frame_err_start", 64'(frame_err), 64'(exp_err));
    end
    for (int k = 0; k < N; k++) applyStimulus(word_of(b, k), 1'b0);
    checkOutput("latency_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic take_pair(input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] ca, input logic [2:0] cb, input int stall);
    checkOutput("A_64", a_64, a);
    checkOutput("B_64", b_64, b);
    checkOutput("a_class", 64'(a_class), 64'(ca));
    checkOutput("b_class", 64'(b_class), 64'(cb));
    out_ready = 1'b0;
    repeat (stall) begin
      in_valid = 1'b1;
      in_first = 1'b1;
      in_data  = 16'($urandom());
      @(posedge clk); #1;
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_A", a_64, a);
      checkOutput("hold_B", b_64, b);
      checkOutput("hold_ready", 64'(in_ready), 64'd0);
      checkOutput("hold_err", 64'(frame_err), 64'd0);
    end
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("release_valid", 64'(out_valid), 64'd0);
    checkOutput("release_ready", 64'(in_ready), 64'd1);
    checkOutput("kept_A", a_64, a);
  endtask

  task automatic pair8(input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] ca, input logic [2:0] cb);
    int guard;
    for (int k = 0; k < 16; k++) begin
      s8_data  = 8'(((k < 8) ? a : b) >> ((7 - (k % 8)) * 8));
      s8_valid = 1'b1;
      s8_first = (k == 0);
      guard    = 0;
      while (!s8_ready && guard < 100) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
    end
    s8_valid = 1'b0;
    s8_first = 1'b0;
    checkOutput("w8_valid", 64'(s8_out_valid), 64'd1);
    checkOutput("w8_A", s8_a, a);
    checkOutput("w8_B", s8_b, b);
    checkOutput("w8_a_class", 64'(s8_ac), 64'(ca));
    checkOutput("w8_b_class", 64'(s8_bc), 64'(cb));
    s8_out_ready = 1'b1;
    @(posedge clk); #1;
    s8_out_ready = 1'b0;
    checkOutput("w8_release", 64'(s8_out_valid), 64'd0);
  endtask

  task automatic pair64(input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] ca, input logic [2:0] cb);
    int guard;
    for (int k = 0; k < 2; k++) begin
      s64_data  = (k == 0) ? a : b;
      s64_valid = 1'b1;
      s64_first = (k == 0);
      guard     = 0;
      while (!s64_ready && guard < 100) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
    end
    s64_valid = 1'b0;
    s64_first = 1'b0;
    checkOutput("w64_valid", 64'(s64_out_valid), 64'd1);
    checkOutput("w64_A", s64_a, a);
    checkOutput("w64_B", s64_b, b);
    checkOutput("w64_a_class", 64'(s64_ac), 64'(ca));
    checkOutput("w64_b_class", 64'(s64_bc), 64'(cb));
    s64_out_ready = 1'b1;
    @(posedge clk); #1;
    s64_out_ready = 1'b0;
    checkOutput("w64_release", 64'(s64_out_valid), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] a, b;
    int ca, cb, k;
    logic rst_err;
    rst_n = 1'b0;
    in_data = '0; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b0;
    s8_data = '0; s8_valid = 1'b0; s8_first = 1'b0; s8_out_ready = 1'b0;
    s64_data = '0; s64_valid = 1'b0; s64_first = 1'b0; s64_out_ready = 1'b0;
    #12;
    checkOutput("reset_A", a_64, 64'd0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset_class", 64'({a_class, b_class}), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] 5.4 pair with 5-cycle backpressure");
    send_pair(P54, P54, 1'b0);
    take_pair(P54, P54, 3'd0, 3'd0, 5);

    $display("[TB] stray word in IDLE");
    applyStimulus(16'h1234, 1'b0);
    checkOutput("idle_drop_err", 64'(frame_err), 64'd1);
    checkOutput("idle_drop_ready", 64'(in_ready), 64'd1);
    checkOutput("idle_drop_A", a_64, P54);
    @(posedge clk); #1;
    checkOutput("idle_drop_pulse", 64'(frame_err), 64'd0);

    $display("[TB] directed classes");
    send_pair(64'h7FF8000000000000, 64'h7FF0000000000001, 1'b0);
    take_pair(64'h7FF8000000000000, 64'h7FF0000000000001, 3'd4, 3'd5, 0);
    send_pair(64'hFFF8000000000000, 64'h7FF0000000000000, 1'b0);
    take_pair(64'hFFF8000000000000, 64'h7FF0000000000000, 3'd4, 3'd3, 0);
    send_pair(64'h7FF8000000000000, 64'h0000000000000000, 1'b0);
    take_pair(64'h7FF8000000000000, 64'h0000000000000000, 3'd4, 3'd1, 1);
    send_pair(64'h7FF8000000000000, 64'h0000000000000001, 1'b0);
    take_pair(64'h7FF8000000000000, 64'h0000000000000001, 3'd4, 3'd2, 0);
    send_pair(64'h8000000000000000, 64'hFFF0000000000001, 1'b0);
    take_pair(64'h8000000000000000, 64'hFFF0000000000001, 3'd1, 3'd5, 0);
    send_pair(64'h8000000000000001, 64'hFFF0000000000000, 1'b0);
    take_pair(64'h8000000000000001, 64'hFFF0000000000000, 3'd2, 3'd3, 0);

    $display("[TB] restart on B word 2");
    for (int j = 0; j < N + 2; j++) applyStimulus(16'hDEAD ^ 16'(j), j == 0);
    checkOutput("partial_no_valid", 64'(out_valid), 64'd0);
    send_pair(P54, 64'hC000000000000000, 1'b1);
    @(posedge clk); #1;
    take_pair(P54, 64'hC000000000000000, 3'd0, 3'd0, 0);

    $display("[TB] in_first on final B word");
    for (int j = 0; j < 2 * N - 1; j++) applyStimulus(16'hBEEF, j == 0);
    send_pair(64'h3FF0000000000000, P54, 1'b1);
    take_pair(64'h3FF0000000000000, P54, 3'd0, 3'd0, 0);

    $display("[TB] randomized pairs");
    gap_en = 1'b1;
    repeat (40) begin
      ca = $urandom_range(5);
      cb = $urandom_range(5);
      a  = make_operand(ca);
      b  = make_operand(cb);
      rst_err = ($urandom_range(3) == 0);
      if (rst_err) begin
        k = $urandom_range(1, 2 * N - 1);
        for (int j = 0; j < k; j++) applyStimulus(16'($urandom()), j == 0);
      end
      send_pair(a, b, rst_err);
      take_pair(a, b, 3'(ca), 3'(cb), $urandom_range(0, 3));
    end
    gap_en = 1'b0;

    $display("[TB] async reset mid-LOAD_B");
    for (int j = 0; j < N + 2; j++) applyStimulus(word_of(64'h0123456789ABCDEF, j % N), j == 0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_A", a_64, 64'd0);
    checkOutput("async_rst_B", b_64, 64'd0);
    checkOutput("async_rst_ready", 64'(in_ready), 64'd0);
    checkOutput("async_rst_valid", 64'(out_valid), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_pair(P54, P54, 1'b0);
    take_pair(P54, P54, 3'd0, 3'd0, 0);

    $display("[TB] 8-bit MSW-first and 64-bit configurations");
    pair8(P54, P54, 3'd0, 3'd0);
    pair64(P54, P54, 3'd0, 3'd0);
    repeat (8) begin
      ca = $urandom_range(5);
      cb = $urandom_range(5);
      a  = make_operand(ca);
      b  = make_operand(cb);
      pair8(a, b, 3'(ca), 3'(cb));
      pair64(b, a, 3'(cb), 3'(ca));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
